// File: rtl/register_pkg.sv
// rtl/register_pkg.sv - shared defaults and data type for the register block
package register_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam logic [DEFAULT_WIDTH-1:0] DEFAULT_RESET_VALUE = '0;

  typedef logic [DEFAULT_WIDTH-1:0] data_t;

endpackage

// File: rtl/register_dff.sv
// rtl/register_dff.sv - enable flop bank with synchronous active-high reset
module register_dff
  import register_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_d;
  logic [WIDTH-1:0] q_q;

  always_comb begin
    q_d = q_q;
    if (en) begin
      q_d = d;
    end
  end

  // Reset wins over the enable.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= RESET_VALUE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/register.sv
// rtl/register.sv - storage register with registered read port; REGISTER_WR_BYPASS_EN selects write-through on simultaneous access
module register
  import register_pkg::*;
#(
  parameter int               WIDTH       = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = WIDTH'(DEFAULT_RESET_VALUE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic             read_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] store
);

  logic [WIDTH-1:0] rd_src;

`ifdef REGISTER_WR_BYPASS_EN
  // Write-through: a read in the same cycle as a write returns the new data.
  assign rd_src = write_en ? data_in : store;
`else
  assign rd_src = store;
`endif

  register_dff #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_store (
    .clk (clk),
    .rst (rst),
    .en  (write_en),
    .d   (data_in),
    .q   (store)
  );

  register_dff #(
    .WIDTH       (WIDTH),
    .RESET_VALUE (RESET_VALUE)
  ) u_data_out (
    .clk (clk),
    .rst (rst),
    .en  (read_en),
    .d   (rd_src),
    .q   (data_out)
  );

endmodule

// File: tb/tb_register.sv
// tb/tb_register.sv - self-checking bench for register with a behavioural reference model
module tb_register;

  localparam int W = 16;

`ifdef REGISTER_WR_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         write_en;
  logic         read_en;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;
  logic [W-1:0] store;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] m_store;
  logic [W-1:0] m_out;

  always #5 clk = ~clk;

  register #(
    .WIDTH       (W),
    .RESET_VALUE ('0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .write_en (write_en),
    .read_en  (read_en),
    .data_in  (data_in),
    .data_out (data_out),
    .store    (store)
  );

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the model by the behavioural rules, return at the negedge.
  task automatic cycle(input logic r, input logic we, input logic re, input logic [W-1:0] d);
    logic [W-1:0] old_store;
    rst      = r;
    write_en = we;
    read_en  = re;
    data_in  = d;
    @(posedge clk);
    old_store = m_store;
    if (r) begin
      m_store = '0;
      m_out   = '0;
    end else begin
      if (re) m_out = (we && BYPASS) ? d : old_store;
      if (we) m_store = d;
    end
    @(negedge clk);
  endtask

  task automatic check_model(input string tag);
    check({tag, "_store"}, store, m_store);
    check({tag, "_out"}, data_out, m_out);
  endtask

  initial begin
    logic [W-1:0] held_store;
    logic [W-1:0] held_out;
    rst = 1'b1; write_en = 1'b0; read_en = 1'b0; data_in = '0;
    m_store = '0; m_out = '0;
    @(negedge clk);

    // Reset with write enabled and all-ones data
    cycle(1'b1, 1'b1, 1'b0, 16'hFFFF);
    cycle(1'b1, 1'b1, 1'b0, 16'hFFFF);
    check("reset_store", store, 16'h0000);
    check("reset_out", data_out, 16'h0000);

    // Write zeros then 0x000F
    for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
    check("wr_zero_store", store, 16'h0000);
    cycle(1'b0, 1'b1, 1'b0, 16'h000F);
    check("wr_f_store", store, 16'h000F);
    check("wr_f_out", data_out, 16'h0000);

    // Read then write without read
    cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    check("rd_out", data_out, 16'h000F);
    cycle(1'b0, 1'b1, 1'b0, 16'h1234);
    check("rd_wr_store", store, 16'h1234);
    check("rd_hold_out", data_out, 16'h000F);

    // Simultaneous access
    cycle(1'b0, 1'b1, 1'b0, 16'h000F);
    cycle(1'b0, 1'b1, 1'b1, 16'h00AA);
    check("simul_store", store, 16'h00AA);
    check("simul_out", data_out, BYPASS ? 16'h00AA : 16'h000F);

    // Reset mid-operation, then release
    cycle(1'b1, 1'b1, 1'b1, 16'h5555);
    check("midrst_store", store, 16'h0000);
    check("midrst_out", data_out, 16'h0000);
    cycle(1'b0, 1'b1, 1'b1, 16'h5555);
    check("post_rst_store", store, 16'h5555);
    check("post_rst_out", data_out, BYPASS ? 16'h5555 : 16'h0000);

    // Idle hold with random data_in
    cycle(1'b0, 1'b0, 1'b1, 16'h0000);
    held_store = store;
    held_out   = data_out;
    check("idle_pre_out", held_out, 16'h5555);
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0, W'($urandom));
      check("idle_store", store, 16'h5555);
      check("idle_out", data_out, 16'h5555);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 31) == 0), 1'($urandom), 1'($urandom), W'($urandom));
      check_model("rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/register.md
REGISTER -- requirements
Module: register

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data and storage width in bits.
REQ-002 SHALL have parameter RESET_VALUE, default 0: value loaded into store and data_out on reset.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port write_en  input  1: when high, data_in is captured into store.
REQ-006 SHALL have port read_en  input  1: when high, store is transferred to data_out.
REQ-007 SHALL have port data_in  input  WIDTH: write data.
REQ-008 SHALL have port data_out  output  WIDTH: registered read data.
REQ-009 SHALL have port store  output  WIDTH: current stored value, driven directly from the storage flops.

Function
REQ-010 SHALL load store with data_in on each rising clk edge where write_en=1 and rst=0.
REQ-011 SHALL hold store unchanged when write_en=0.
REQ-012 SHALL load data_out with store's pre-edge value on each rising clk edge where read_en=1 and rst=0; read latency is 1 cycle.
REQ-013 SHALL hold data_out at its last value when read_en=0; data_out SHALL NOT return to zero.
REQ-014 SHALL treat write_en=1 with read_en=1 in the same cycle as follows: store takes data_in; data_out takes the old store value. This is the default; REQ-020 covers the alternative.
REQ-015 SHALL treat write_en and read_en as independent level qualifiers with no handshake; every cycle with an enable high is one operation.
REQ-016 SHALL use pure WIDTH-bit transfers with no arithmetic, truncation or extension.
REQ-017 SHALL keep store and data_out free of X once reset has been applied, for any enable combination.

Reset
REQ-018 SHALL set store=RESET_VALUE and data_out=RESET_VALUE on a rising clk edge with rst=1.
REQ-019 SHALL give rst priority over write_en and read_en, including a reset asserted mid-sequence; enables are ignored while rst=1.

Configuration
REQ-020 SHALL, with macro REGISTER_WR_BYPASS_EN defined, load data_out with data_in (write-through) when write_en=1 and read_en=1 in the same cycle.
REQ-021 SHALL, without REGISTER_WR_BYPASS_EN, use the REQ-014 behaviour; all other behaviour is identical in both builds.

Structure
REQ-022 SHALL place the default WIDTH (16) and default RESET_VALUE constants, plus a data_t typedef of width WIDTH, in shared package register_pkg.
REQ-023 SHALL use a single sub-module register_dff, an enable flop bank with synchronous reset, instantiated twice: once for store and once for data_out.
REQ-024 SHALL contain no latches and no combinational path from inputs to data_out; store SHALL be a direct flop output.

Verification
REQ-025 SHALL cover reset: rst=1 for 2 cycles with write_en=1, data_in=0xFFFF -> store=0x0000, data_out=0x0000.
REQ-026 SHALL cover write: rst=0, write_en=1, data_in=0 for 10 cycles, then data_in=15 (0x000F) -> store=0x000F one edge later; data_out remains 0x0000 while read_en=0.
REQ-027 SHALL cover read: with store=0x000F, read_en=1 -> data_out=0x000F one edge later; then read_en=0, data_in=0x1234 -> store=0x1234 and data_out still 0x000F.
REQ-028 SHALL cover simultaneous access: store=0x000F, write_en=1, read_en=1, data_in=0x00AA for one edge -> store=0x00AA; data_out=0x000F without the macro, 0x00AA with REGISTER_WR_BYPASS_EN.
REQ-029 SHALL cover reset mid-operation: write_en=1, read_en=1, data_in=0x5555, rst=1 for one edge -> store=0x0000, data_out=0x0000; rst=0 next edge -> store=0x5555.
REQ-030 SHALL cover idle hold: write_en=0, read_en=0 for 20 cycles with random data_in -> store and data_out unchanged.
